// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, FSM state encoding and a divisor helper.
package mmio_pkg;

    // Register offsets relative to the peripheral base address.
    localparam logic [31:0] OFF_TXDATA  = 32'd0;
    localparam logic [31:0] OFF_STATUS  = 32'd4;
    localparam logic [31:0] OFF_DIVISOR = 32'd8;

    // STATUS register bit positions.
    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_FULL_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;

    // Transmit FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // A zero bit period would never finish a bit, so it is stored as 1.
    function automatic logic [15:0] sanitize_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with combinational head output. Pointers wrap naturally
// (DEPTH is a power of two); full/empty come from an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign dout      = mem_r[rd_ptr_r];

    // Storage array: written on every accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter. CPU stores to TXDATA are queued in
// a byte FIFO and shifted out LSB first; STATUS and DIVISOR are readable.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          n         = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE      = 32'h0000_0100,
    parameter int          DIV_RESET = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memWrite,
    input  logic [n-1:0] dataAddr,
    input  logic [n-1:0] writeData,
    output logic [n-1:0] readData,
    output logic         txd,
    output logic         txBusy
);

    localparam logic [n-1:0] ADDR_TX  = n'(BASE + OFF_TXDATA);
    localparam logic [n-1:0] ADDR_ST  = n'(BASE + OFF_STATUS);
    localparam logic [n-1:0] ADDR_DIV = n'(BASE + OFF_DIVISOR);
    localparam logic [15:0]  DIV_RST_V = 16'(DIV_RESET);

    logic        sel_tx_s;
    logic        sel_st_s;
    logic        sel_div_s;
    logic [15:0] divisor_r;
    logic        overflow_r;

    logic [7:0]  fifo_dout_s;
    logic        full_s;
    logic        empty_s;
    logic        pop_s;
    logic        busy_s;

    tx_state_t   state_r;
    tx_state_t   state_next_s;
    logic [15:0] timer_r;
    logic [15:0] timer_next_s;
    logic [2:0]  bit_cnt_r;
    logic [2:0]  bit_cnt_next_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_next_s;
    logic [15:0] frame_div_r;
    logic [15:0] frame_div_next_s;
    logic        bit_done_s;
    logic        txd_r;
    logic        txd_next_s;
    logic        unused_wdata_s;

    assign sel_tx_s   = memWrite & (dataAddr == ADDR_TX);
    assign sel_st_s   = memWrite & (dataAddr == ADDR_ST);
    assign sel_div_s  = memWrite & (dataAddr == ADDR_DIV);
    assign busy_s     = (state_r != IDLE) | ~empty_s;
    assign bit_done_s = (timer_r == (frame_div_r - 16'd1));
    assign txd        = txd_r;
    assign txBusy     = busy_s;
    assign unused_wdata_s = ^writeData[n-1:16];

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sel_tx_s),
        .pop   (pop_s),
        .din   (writeData[7:0]),
        .dout  (fifo_dout_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Divisor register and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor_r  <= DIV_RST_V;
            overflow_r <= 1'b0;
        end else begin
            if (sel_div_s) begin
                divisor_r <= sanitize_div(writeData[15:0]);
            end else begin
                divisor_r <= divisor_r;
            end
            if (sel_tx_s & full_s & ~pop_s) begin
                overflow_r <= 1'b1;
            end else if (sel_st_s & writeData[ST_OVF_BIT]) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Combinational register readback; reads have no side effects.
    always_comb begin
        readData = '0;
        if (dataAddr == ADDR_ST) begin
            readData[ST_OVF_BIT]   = overflow_r;
            readData[ST_FULL_BIT]  = full_s;
            readData[ST_EMPTY_BIT] = empty_s;
            readData[ST_BUSY_BIT]  = busy_s;
        end else if (dataAddr == ADDR_DIV) begin
            readData[15:0] = divisor_r;
        end else begin
            readData = '0;
        end
    end

    // FSM state register together with the datapath it sequences.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            timer_r     <= 16'd0;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'd0;
            frame_div_r <= DIV_RST_V;
            txd_r       <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            timer_r     <= timer_next_s;
            bit_cnt_r   <= bit_cnt_next_s;
            shift_r     <= shift_next_s;
            frame_div_r <= frame_div_next_s;
            txd_r       <= txd_next_s;
        end
    end

    // Next-state logic: bit timer restarts on every state or bit change.
    always_comb begin
        state_next_s     = state_r;
        timer_next_s     = timer_r + 16'd1;
        bit_cnt_next_s   = bit_cnt_r;
        shift_next_s     = shift_r;
        frame_div_next_s = frame_div_r;
        case (state_r)
            IDLE: begin
                timer_next_s   = 16'd0;
                bit_cnt_next_s = 3'd0;
                if (!empty_s) begin
                    state_next_s     = START;
                    shift_next_s     = fifo_dout_s;
                    frame_div_next_s = divisor_r;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (bit_done_s) begin
                    state_next_s   = DATA;
                    timer_next_s   = 16'd0;
                    bit_cnt_next_s = 3'd0;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    timer_next_s = 16'd0;
                    if (bit_cnt_r == 3'd7) begin
                        state_next_s = STOP;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                        shift_next_s   = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    state_next_s = IDLE;
                    timer_next_s = 16'd0;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
                timer_next_s = 16'd0;
            end
        endcase
    end

    // Output logic: FIFO pop strobe and the next serial line level.
    always_comb begin
        pop_s = (state_r == IDLE) & ~empty_s;
        case (state_next_s)
            START:   txd_next_s = 1'b0;
            DATA:    txd_next_s = shift_next_s[0];
            STOP:    txd_next_s = 1'b1;
            IDLE:    txd_next_s = 1'b1;
            default: txd_next_s = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TX  = 32'h0000_0100;
    localparam logic [31:0] A_ST  = 32'h0000_0104;
    localparam logic [31:0] A_DIV = 32'h0000_0108;

    logic        clk;
    logic        reset;
    logic        memWrite;
    logic [31:0] dataAddr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        txd;
    logic        txBusy;

    int n_cmp = 0;
    int n_err = 0;

    mmio_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .memWrite  (memWrite),
        .dataAddr  (dataAddr),
        .writeData (writeData),
        .readData  (readData),
        .txd       (txd),
        .txBusy    (txBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Store accepted at the next posedge; returns 1 time unit after it.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        memWrite  = 1'b1;
        dataAddr  = addr;
        writeData = data;
        @(posedge clk);
        #1;
        memWrite  = 1'b0;
        dataAddr  = 32'd0;
        writeData = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] val);
        dataAddr = addr;
        #1;
        val = readData;
        dataAddr = 32'd0;
    endtask

    // Called 1 unit after the edge that enters START; samples every clock of
    // the 10-bit frame and requires each bit to be stable for div clocks.
    task automatic check_frame(input string tag, input logic [7:0] b, input int div);
        logic [9:0] exp_v;
        logic [9:0] and_v;
        logic [9:0] or_v;
        logic       busy_all;
        exp_v    = {1'b1, b, 1'b0};
        and_v    = 10'h3FF;
        or_v     = 10'h000;
        busy_all = 1'b1;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < div; c++) begin
                and_v[i] = and_v[i] & txd;
                or_v[i]  = or_v[i] | txd;
                busy_all = busy_all & txBusy;
                @(posedge clk);
                #1;
            end
        end
        check_val(tag, {11'd0, busy_all, or_v, and_v}, {11'd0, 1'b1, exp_v, exp_v});
    endtask

    logic [31:0] rd;
    logic        hi_all;
    logic        busy_any;

    initial begin
        reset     = 1'b1;
        memWrite  = 1'b0;
        dataAddr  = 32'd0;
        writeData = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("txd_in_reset", {31'd0, txd}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        bus_read(A_ST, rd);
        check_val("status_rst", rd, 32'h2);
        bus_read(A_DIV, rd);
        check_val("div_rst", rd, 32'd16);
        check_val("txd_rst", {31'd0, txd}, 32'd1);
        check_val("busy_rst", {31'd0, txBusy}, 32'd0);
        bus_read(32'h0000_0200, rd);
        check_val("other_addr", rd, 32'd0);

        // Single frame at divisor 4
        bus_write(A_DIV, 32'd4);
        bus_read(A_DIV, rd);
        check_val("div4", rd, 32'd4);
        bus_write(A_TX, 32'h0000_0096);
        check_val("busy_after_push", {31'd0, txBusy}, 32'd1);
        @(posedge clk);
        #1;
        check_frame("frame_96", 8'h96, 4);
        check_val("busy_after_96", {31'd0, txBusy}, 32'd0);
        check_val("txd_after_96", {31'd0, txd}, 32'd1);

        // Overflow with divisor 1 and back-to-back frames
        bus_write(A_DIV, 32'd1);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    bus_write(A_TX, 32'hA1 + i);
                end
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                for (int f = 0; f < 5; f++) begin
                    check_frame($sformatf("frame_A%0d", f + 1), 8'hA1 + 8'(f), 1);
                    if (f < 4) begin
                        check_val($sformatf("gap_txd_%0d", f), {31'd0, txd}, 32'd1);
                        check_val($sformatf("gap_busy_%0d", f), {31'd0, txBusy}, 32'd1);
                        @(posedge clk);
                        #1;
                    end else begin
                        check_val("busy_after_A5", {31'd0, txBusy}, 32'd0);
                    end
                end
            end
        join
        repeat (15) @(posedge clk);
        #1;
        check_val("no_A6_txd", {31'd0, txd}, 32'd1);
        check_val("no_A6_busy", {31'd0, txBusy}, 32'd0);
        bus_read(A_ST, rd);
        check_val("status_ovf", rd, 32'hA);
        bus_write(A_ST, 32'h7);
        bus_read(A_ST, rd);
        check_val("status_ovf_kept", rd, 32'hA);
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, rd);
        check_val("status_ovf_clr", rd, 32'h2);

        // Zero divisor is stored as one
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, rd);
        check_val("div_zero", rd, 32'd1);
        bus_write(A_DIV, 32'hABCD_0007);
        bus_read(A_DIV, rd);
        check_val("div_upper_ign", rd, 32'd7);

        // Divisor change mid-frame applies to the next frame only
        bus_write(A_DIV, 32'd2);
        bus_write(A_TX, 32'h0000_003C);
        fork
            begin
                bus_write(A_TX, 32'h0000_00C3);
                repeat (3) @(posedge clk);
                bus_write(A_DIV, 32'd5);
            end
            begin
                @(posedge clk);
                #1;
                check_frame("frame_3C_div2", 8'h3C, 2);
                check_val("gap_div", {31'd0, txd}, 32'd1);
                @(posedge clk);
                #1;
                check_frame("frame_C3_div5", 8'hC3, 5);
                check_val("busy_after_C3", {31'd0, txBusy}, 32'd0);
            end
        join
        bus_read(A_DIV, rd);
        check_val("div5", rd, 32'd5);

        // Reset mid-DATA with two bytes queued
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'h0000_0055);
        bus_write(A_TX, 32'h0000_0066);
        bus_write(A_TX, 32'h0000_0077);
        repeat (7) @(posedge clk);
        #1;
        check_val("pre_rst_txd", {31'd0, txd}, 32'd0);
        bus_read(A_ST, rd);
        check_val("pre_rst_status", rd, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check_val("rst_txd_async", {31'd0, txd}, 32'd1);
        check_val("rst_busy_async", {31'd0, txBusy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus_read(A_ST, rd);
        check_val("post_rst_status", rd, 32'h2);
        bus_read(A_DIV, rd);
        check_val("post_rst_div", rd, 32'd16);
        hi_all   = 1'b1;
        busy_any = 1'b0;
        for (int i = 0; i < 60; i++) begin
            hi_all   = hi_all & txd;
            busy_any = busy_any | txBusy;
            @(posedge clk);
            #1;
        end
        check_val("post_rst_idle", {30'd0, busy_any, hi_all}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped serial transmit peripheral that answers CPU data-memory stores, the responder side of the `memWrite`/`dataAddr`/`writeData` bus the computer drives. Stores to its address window are queued in a small byte FIFO and shifted out on `txd` as 8N1 frames at a programmable bit period. Status and divisor registers are readable on the same address bus. It sits beside `dmem` in the computer, with `memWrite` qualified by address decode, so programs can emit results serially instead of only through RAM checks.

## Interface
- `n`, 32, width of the data/address bus.
- `DEPTH`, 4, number of FIFO entries (power of two, ≥2).
- `BASE`, 32'h0000_0100, word address of the TXDATA register; STATUS = BASE+4, DIVISOR = BASE+8.
- `DIV_RESET`, 16, bit period in clocks after reset.

- `clk`  in  1  system clock, all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `memWrite`  in  1  store strobe from the CPU.
- `dataAddr`  in  n  byte address of the load or store.
- `writeData`  in  n  store data.
- `readData`  out  n  combinational register readback.
- `txd`  out  1  serial line, idle high.
- `txBusy`  out  1  high while a frame is in flight or the FIFO is non-empty.

## Operation
- Reset values: `txd`=1, `txBusy`=0, FIFO empty, overflow=0, divisor=DIV_RESET, FSM=IDLE. `readData` follows the reset register values.
- Write to TXDATA (`memWrite` & `dataAddr`==BASE): push `writeData[7:0]`. If the FIFO is full after considering a same-cycle pop, the byte is dropped and sticky overflow is set.
- Write to STATUS: if `writeData[3]`=1, clear overflow. All other bits are ignored.
- Write to DIVISOR: load `writeData[15:0]`. A value of 0 is stored as 1.
- Writes to any other address are ignored. Reads have no side effects.
- `readData`:
  - STATUS → {28'b0, overflow, full, empty, busy}.
  - DIVISOR → {16'b0, divisor}.
  - Any other address → 0.
- FSM IDLE/START/DATA/STOP:
  - IDLE: `txd`=1. If FIFO non-empty, pop into the shift register, latch the divisor into the frame divisor, go to START.
  - START: `txd`=0 for one bit period, then go to DATA.
  - DATA: 8 bits, LSB first, one bit period each, tracked by a 3-bit bit counter. Then go to STOP.
  - STOP: `txd`=1 for one bit period, then go to IDLE.
- Bit period equals the frame divisor clocks. The bit timer is reset at every state or bit change.
- A divisor write during a frame affects only the next frame.

## Timing
- A store accepted at edge k makes the FIFO non-empty after edge k. IDLE pops at edge k+1, and `txd` falls after edge k+1.
- A frame lasts 10·div clocks. There is 1 IDLE clock between back-to-back frames, so the frame period is 10·div+1.
- Simultaneous push and pop are both performed, and the count is unchanged.
- A push while full with no pop in the same cycle drops the byte.
- `txBusy` = (state≠IDLE) | ~empty, registered-state based.
- Pointers wrap modulo DEPTH. Full and empty are derived from a count of width log2(DEPTH)+1.
- Reset asserted mid-frame: `txd` goes high immediately (asynchronous), and all state returns to its reset values.

## Structure
- Package `mmio_pkg`:
  - Register offsets (TXDATA=0, STATUS=4, DIVISOR=8).
  - STATUS bit indices.
  - `tx_state_t` enum {IDLE, START, DATA, STOP}.
- Sub-module `byte_fifo` (parameter DEPTH):
  - Inputs: push, pop, din[7:0].
  - Outputs: dout, full, empty.
  - Same-cycle push and pop when full is legal.
- The top level holds address decode, registers, the FSM, the bit timer and the shift register.

## Test plan
- Reset then read STATUS → 0x2 (empty). Read DIVISOR → 16. `txd`=1.
- DIVISOR=4, store 0x96 to BASE → after the next edge, `txd` shows 0 for 4 clks, then 0,1,1,0,1,0,0,1 for 4 clks each, then 1 for 4 clks. `txBusy` is high throughout the 40 clks and low 1 clk after.
- DIVISOR=1, six back-to-back stores 0xA1..0xA6 while idle → 0xA6 dropped, STATUS bit3=1. `txd` emits 0xA1..0xA5 with 11-clk frame period. Store 0x8 to STATUS → overflow cleared.
- Store 0 to DIVISOR → readback 1.
- DIVISOR=2, start a frame, write DIVISOR=5 mid-frame → the current frame keeps 2-clk bits and the next frame uses 5.
- Assert `reset` mid-DATA with 2 bytes queued → `txd`=1 within the same cycle. After release, STATUS=0x2 and no further frames are sent.
